// File: rtl/sub4bit_serial.sv
// Bit-serial subtractor: Diff = A - B - Bin, resolved one bit per clock LSB first
// through a single borrow flop, with a start/busy/done handshake.
module sub4bit_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             br_next;

  // One-bit full subtractor on the current LSBs of the shifting operand copies.
  always_comb begin
    sum_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        if (cnt_q == CNT_LAST) begin
          diff_d   = {sum_bit, res_q[WIDTH-1:1]};
          borrow_d = br_next;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_sub4bit_serial.sv
// Scoreboard bench for sub4bit_serial: a driver queues expected results from an
// arithmetic model, a negedge monitor pops and compares on every done pulse.
module tb_sub4bit_serial;

  localparam int unsigned W  = 4;
  localparam int unsigned W8 = 8;

  typedef struct {
    int unsigned diff;
    int unsigned borrow;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic bin = 1'b0;
  logic busy, done, borrow;
  logic [W-1:0] diff;

  logic start8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic bin8 = 1'b0;
  logic busy8, done8, borrow8;
  logic [W8-1:0] diff8;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int pushed = 0;
  int busy_run = 0;
  exp_t sb[$];
  exp_t e;

  sub4bit_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
    .busy(busy), .done(done), .Diff(diff), .Borrow(borrow)
  );

  sub4bit_serial #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borrow(borrow8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer subtraction, reduced modulo 2^w.
  function automatic exp_t model(input int x, input int y, input int bi, input int w, input int c);
    exp_t r;
    int d;
    d = x - y - bi;
    r.diff = int'(d) & ((1 << w) - 1);
    r.borrow = (d < 0) ? 1 : 0;
    r.cyc = c;
    return r;
  endfunction

  // Issue one operation; returns at the edge before the earliest legal restart.
  task automatic issue(input int x, input int y, input int bi);
    @(negedge clk);
    a = W'(x); b = W'(y); bin = bi[0]; start = 1'b1;
    sb.push_back(model(x, y, bi, W, cyc + 1 + W));
    pushed++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    check("busy_done_overlap", 32'(busy & done), 32'd0);
    if (done) begin
      done_cnt++;
      check("busy_length", busy_run, W);
      busy_run = 0;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("diff", 32'(diff), e.diff);
        check("borrow", 32'(borrow), e.borrow);
        check("done_latency", cyc, e.cyc);
      end
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int k;
    exp_t r8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;

    issue(9, 3, 0);
    issue(3, 9, 0);
    issue(0, 0, 1);
    issue(8, 7, 1);

    // Start requests while busy and during DONE must be dropped.
    @(negedge clk);
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    sb.push_back(model(5, 2, 0, W, cyc + 1 + W));
    pushed++;
    @(posedge clk);
    @(negedge clk);
    a = 4'd1; b = 4'd4;
    repeat (W + 1) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold_diff", 32'(diff), 32'd3);
    check("hold_borrow", 32'(borrow), 32'd0);

    // Mid-operation reset aborts with no done and clears the result.
    issue(12, 4, 0);
    @(negedge clk);
    a = 4'd2; b = 4'd7; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    repeat (10) @(posedge clk);
    issue(7, 2, 0);

    // Exhaustive sweep at back-to-back spacing.
    base = done_cnt;
    for (int bi = 0; bi < 2; bi++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          issue(x, y, bi);
    check("sweep_done_count", done_cnt - base, 32'd512);

    // Random operands with random idle gaps.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(3)) @(posedge clk);
      issue(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
    end

    // Wider instance: latency and result.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b1; start8 = 1'b1;
    r8 = model(16, 1, 1, W8, 0);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("w8_busy", 32'(busy8), 32'd1);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        k = i;
        break;
      end
    end
    check("w8_latency", k, W8);
    check("w8_diff", 32'(diff8), r8.diff);
    check("w8_borrow", 32'(borrow8), r8.borrow);
    check("w8_diff_value", 32'(diff8), 32'h0E);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("done_count", done_cnt, pushed);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
